// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU results take the port, load results queue behind them.
// Define WB_PENDING_MASK_EN to add the pendingMask output (live queued destinations).
module wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  aluValid,
    input  logic [ADDR_WIDTH-1:0] aluReg,
    input  logic [DATA_WIDTH-1:0] aluData,
    input  logic                  memValid,
    input  logic [ADDR_WIDTH-1:0] memReg,
    input  logic [DATA_WIDTH-1:0] memData,
    output logic                  memReady,
    output logic                  regWrite,
    output logic [ADDR_WIDTH-1:0] writeReg,
    output logic [DATA_WIDTH-1:0] writeData
`ifdef WB_PENDING_MASK_EN
    ,
    output logic [2**ADDR_WIDTH-1:0] pendingMask
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [IDX_W:0]          rd_ptr_q, rd_ptr_d;
    logic [IDX_W:0]          wr_ptr_q, wr_ptr_d;
    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [DEPTH-1:0]        kill_q, kill_d;
    logic                    regWrite_q, regWrite_d;
    logic [ADDR_WIDTH-1:0]   writeReg_q, writeReg_d;
    logic [DATA_WIDTH-1:0]   writeData_q, writeData_d;

    logic [ADDR_WIDTH-1:0]   reg_mem  [DEPTH];
    logic [DATA_WIDTH-1:0]   data_mem [DEPTH];

    logic [IDX_W-1:0]        rd_idx, wr_idx;
    logic                    empty, full, accept, load_live, alu_live;
    logic                    push, push_kill;

    assign rd_idx    = rd_ptr_q[IDX_W-1:0];
    assign wr_idx    = wr_ptr_q[IDX_W-1:0];
    assign empty     = (rd_ptr_q == wr_ptr_q);
    assign full      = (rd_ptr_q[IDX_W] != wr_ptr_q[IDX_W]) && (rd_idx == wr_idx);
    assign memReady  = !full;
    assign accept    = memValid && memReady;
    // Destination 0 is accepted but never written and never queued.
    assign load_live = accept && (memReg != '0);
    assign alu_live  = aluValid && (aluReg != '0);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        valid_d     = valid_q;
        kill_d      = kill_q;
        regWrite_d  = 1'b0;
        writeReg_d  = writeReg_q;
        writeData_d = writeData_q;
        push        = 1'b0;
        push_kill   = 1'b0;

        if (aluValid) begin
            if (alu_live) begin
                regWrite_d  = 1'b1;
                writeReg_d  = aluReg;
                writeData_d = aluData;
                for (int i = 0; i < DEPTH; i++) begin
                    if (valid_q[i] && (reg_mem[i] == aluReg))
                        kill_d[i] = 1'b1;
                end
            end
            // A same-cycle load to the ALU's register is older, so it is queued already dead.
            push      = load_live;
            push_kill = alu_live && (memReg == aluReg);
        end else if (!empty) begin
            regWrite_d = !kill_q[rd_idx];
            if (!kill_q[rd_idx]) begin
                writeReg_d  = reg_mem[rd_idx];
                writeData_d = data_mem[rd_idx];
            end
            valid_d[rd_idx] = 1'b0;
            kill_d[rd_idx]  = 1'b0;
            rd_ptr_d        = rd_ptr_q + (IDX_W+1)'(1);
            push            = load_live;
        end else if (load_live) begin
            regWrite_d  = 1'b1;
            writeReg_d  = memReg;
            writeData_d = memData;
        end

        if (push) begin
            valid_d[wr_idx] = 1'b1;
            kill_d[wr_idx]  = push_kill;
            wr_ptr_d        = wr_ptr_q + (IDX_W+1)'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            valid_q     <= '0;
            kill_q      <= '0;
            regWrite_q  <= 1'b0;
            writeReg_q  <= '0;
            writeData_q <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            valid_q     <= valid_d;
            kill_q      <= kill_d;
            regWrite_q  <= regWrite_d;
            writeReg_q  <= writeReg_d;
            writeData_q <= writeData_d;
        end
    end

    // NOTE: payload storage has no reset; valid/kill bits and pointers alone define what is live.
    always_ff @(posedge clock) begin
        if (push) begin
            reg_mem[wr_idx]  <= memReg;
            data_mem[wr_idx] <= memData;
        end
    end

    assign regWrite  = regWrite_q;
    assign writeReg  = writeReg_q;
    assign writeData = writeData_q;

`ifdef WB_PENDING_MASK_EN
    always_comb begin
        pendingMask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !kill_q[i])
                pendingMask[reg_mem[i]] = 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter: ALU priority, bypass, back-pressure, kill, x0, reset.
module tb_wb_arbiter;

    logic        clock;
    logic        reset;
    logic        aluValid;
    logic [4:0]  aluReg;
    logic [31:0] aluData;
    logic        memValid;
    logic [4:0]  memReg;
    logic [31:0] memData;
    logic        memReady;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
`ifdef WB_PENDING_MASK_EN
    logic [31:0] pendingMask;
`endif

    int checks = 0;
    int errors = 0;

    wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .aluValid  (aluValid),
        .aluReg    (aluReg),
        .aluData   (aluData),
        .memValid  (memValid),
        .memReg    (memReg),
        .memData   (memData),
        .memReady  (memReady),
        .regWrite  (regWrite),
        .writeReg  (writeReg),
        .writeData (writeData)
`ifdef WB_PENDING_MASK_EN
        ,
        .pendingMask (pendingMask)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic chk_w(input string tag, input logic we, input logic [4:0] r, input logic [31:0] d);
        check({tag, ".regWrite"}, 64'(regWrite), 64'(we));
        check({tag, ".writeReg"}, 64'(writeReg), 64'(r));
        check({tag, ".writeData"}, 64'(writeData), 64'(d));
    endtask

    task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md);
        aluValid = av; aluReg = ar; aluData = ad;
        memValid = mv; memReg = mr; memData = md;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int li;
        reset = 1'b1;
        idle();
        #3;
        chk_w("reset", 1'b0, 5'd0, 32'h0);
        check("reset.memReady", 64'(memReady), 64'd1);
        @(posedge clock);
        #1 reset = 1'b0;

        // Single ALU write
        drive(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h0);
        tick();
        chk_w("alu", 1'b1, 5'd3, 32'h11);
        idle();
        tick();
        chk_w("alu_idle", 1'b0, 5'd3, 32'h11);

        // Bypass of an empty queue
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hA5);
        check("bypass.memReady", 64'(memReady), 64'd1);
        tick();
        chk_w("bypass", 1'b1, 5'd5, 32'hA5);
        idle();
        tick();
        chk_w("bypass_after", 1'b0, 5'd5, 32'hA5);

        // Back-pressure: ALU busy for 6 cycles, loads to x1..x6
        li = 1;
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 5'(16 + k), 32'h1000 + k, 1'b1, 5'(li), 32'h100 + li);
            check("bp.memReady", 64'(memReady), (k <= 4) ? 64'd1 : 64'd0);
            tick();
            chk_w("bp.alu", 1'b1, 5'(16 + k), 32'h1000 + k);
            if (k <= 4) li++;
        end
        for (int k = 1; k <= 6; k++) begin
            if (li <= 6) drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(li), 32'h100 + li);
            else idle();
            if (li <= 6) check("bp.drain_ready", 64'(memReady), (k == 1) ? 64'd0 : 64'd1);
            tick();
            chk_w("bp.drain", 1'b1, 5'(k), 32'h100 + k);
            if (li <= 6 && k != 1) li++;
        end
        idle();
        tick();
        chk_w("bp.empty", 1'b0, 5'd6, 32'h106);

        // Kill of a queued load by a later ALU write
        drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd7, 32'hDEAD);
        tick();
        chk_w("kill.setup", 1'b1, 5'd9, 32'h99);
`ifdef WB_PENDING_MASK_EN
        check("kill.pending", 64'(pendingMask), 64'h80);
`endif
        drive(1'b1, 5'd7, 32'hBEEF, 1'b0, 5'd0, 32'h0);
        tick();
        chk_w("kill.alu", 1'b1, 5'd7, 32'hBEEF);
        idle();
        tick();
        chk_w("kill.slot", 1'b0, 5'd7, 32'hBEEF);
        tick();
        chk_w("kill.after", 1'b0, 5'd7, 32'hBEEF);

        // Same-cycle load and ALU write to one register: load is older and dies
        drive(1'b1, 5'd8, 32'h88, 1'b1, 5'd8, 32'h44);
        tick();
        chk_w("same.alu", 1'b1, 5'd8, 32'h88);
        idle();
        tick();
        chk_w("same.slot", 1'b0, 5'd8, 32'h88);
        tick();
        chk_w("same.after", 1'b0, 5'd8, 32'h88);

        // Destination x0 from an idle queue
        drive(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
        tick();
        chk_w("x0.idle", 1'b0, 5'd8, 32'h88);
        idle();
        tick();
        chk_w("x0.idle_after", 1'b0, 5'd8, 32'h88);

        // Destination x0 with one entry queued: occupancy stays at one
        drive(1'b1, 5'd10, 32'hA0, 1'b1, 5'd12, 32'hC0);
        tick();
        chk_w("x0.setup", 1'b1, 5'd10, 32'hA0);
        drive(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
        tick();
        chk_w("x0.busy", 1'b0, 5'd10, 32'hA0);
        idle();
        tick();
        chk_w("x0.pop", 1'b1, 5'd12, 32'hC0);
        tick();
        chk_w("x0.empty", 1'b0, 5'd12, 32'hC0);

        // Reset with three queued loads
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 5'(20 + k), 32'h200 + k, 1'b1, 5'(k), 32'h300 + k);
            tick();
            chk_w("rst.fill", 1'b1, 5'(20 + k), 32'h200 + k);
        end
        idle();
        #1 reset = 1'b1;
        #1;
        chk_w("rst.async", 1'b0, 5'd0, 32'h0);
        check("rst.memReady", 64'(memReady), 64'd1);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_w("rst.after", 1'b0, 5'd0, 32'h0);
            check("rst.after_ready", 64'(memReady), 64'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
